bcs_based_comparator: RTL and testbench
=======================================

// Module: bcs_based_comparator
// PURPOSE
//  Unsigned magnitude comparator of two N-bit operands built as a ripple chain of
//  bit comparator slices (BCS), scanned MSB to LSB.
//  Provides combinational EQ/GT outputs for delay characterisation.
//  Also provides clocked copies eq_q/gt_q for synchronous consumers.
//  Sits in the datapath wherever an a==b / a>b decision is needed.
// PARAMETERS
//  N  8  operand width in bits; legal N>=1; first positional parameter
// PORTS
//  clk      in   1  single clock; registers update on rising edge
//  reset_n  in   1  asynchronous, active-low reset; clears registered outputs only
//  a        in   N  unsigned operand A
//  b        in   N  unsigned operand B
//  EQ       out  1  combinational: 1 iff a==b
//  GT       out  1  combinational: 1 iff a>b (unsigned)
//  eq_q     out  1  EQ registered on rising clk edge
//  gt_q     out  1  GT registered on rising clk edge
// BEHAVIOUR
//  - Port order for instantiation: a, b, EQ, GT first, then clk, reset_n, eq_q, gt_q.
//  - Slice i (i=N-1..0) inputs: eq_in, gt_in, a[i], b[i].
//  - Slice i outputs:
//      eq_out = eq_in & ~(a[i]^b[i])
//      gt_out = gt_in | (eq_in & a[i] & ~b[i])
//  - Chain head (slice N-1): eq_in=1, gt_in=0.
//  - EQ/GT = eq_out/gt_out of slice 0.
//  - EQ and GT are never both 1; EQ=0,GT=0 means a<b.
//  - EQ/GT are purely combinational, with no clock or reset dependence.
//  - EQ/GT are settled within N slice delays of the last input change.
//  - Worst-case path is a change on bit N-1 rippling to slice 0; a change on bit 0
//    has one slice delay.
//  - Each slice is modelled with gate primitives (or continuous assigns).
//  - Optional per-gate #delay is for characterisation only; functional behaviour is
//    delay-independent.
//  - eq_q/gt_q: 1-cycle latency from a/b sampled at a rising edge.
//  - reset_n=0 forces eq_q=0, gt_q=0 immediately, regardless of clk.
//  - Release of reset_n: first rising edge with reset_n=1 loads the current EQ/GT.
//  - Reset asserted mid-operation: registered outputs clear at once; combinational
//    outputs unaffected.
//  - X/Z on any a/b bit may propagate X to outputs; no X-masking required.
//  - Boundaries:
//      a=b=0            -> EQ=1
//      a=2^N-1, b=0     -> GT=1
//      a=0, b=2^N-1     -> EQ=0, GT=0
// STRUCTURE
//  - No shared package needed; the only constant is N.
//  - One sub-module: bcs_slice
//      ports: eq_in, gt_in, a_i, b_i, eq_out, gt_out
//      instantiated N times via generate, chained MSB->LSB.
//  - Top adds the two flops for eq_q/gt_q.
// TESTING
//  - Exhaustive N=8: all 65536 (a,b) pairs.
//      EQ==(a==b), GT==(a>b) after settling.
//      eq_q/gt_q match one edge later.
//  - a=8'h80,b=8'h7F -> GT=1,EQ=0; a=8'h7F,b=8'h80 -> GT=0,EQ=0 (MSB decides).
//  - a=b=8'hA5 -> EQ=1,GT=0; then flip a[0] to 8'hA4 -> EQ=0,GT=0 within 1 slice delay.
//  - Ripple-delay characterisation with unit gate delays:
//      toggle a[7] vs a[0] from equal operands.
//      Settle time for bit 7 >= settle time for bit 0; max <= N slice delays.
//  - Reset: drive a=5,b=3, clock so gt_q=1.
//      Assert reset_n=0 between edges -> eq_q=gt_q=0 immediately.
//      Release -> next edge gt_q=1.
//  - N=1 instance: (0,0)->EQ; (1,0)->GT; (0,1)->neither.

Source files
------------

// File: rtl/bcs_based_comparator_pkg.sv
// Shared constants for the bit-comparator-slice (BCS) magnitude comparator.
// Holds the chain-head seed values and a small helper for decoding a compare result.
package bcs_based_comparator_pkg;

   // Seed values fed into the MSB slice.
   // Operands start out "equal so far, not greater".
   localparam logic CHAIN_EQ_INIT = 1'b1;
   localparam logic CHAIN_GT_INIT = 1'b0;

   // Three-way outcome of an unsigned compare.
   typedef enum logic [1:0] {
      CMP_LT = 2'b00,
      CMP_EQ = 2'b01,
      CMP_GT = 2'b10,
      CMP_XX = 2'b11
   } cmp_res_e;

   // Map an (eq, gt) pair onto the three-way outcome.
   // Both-set is unreachable in a healthy chain and is reported as CMP_XX.
   function automatic cmp_res_e cmp_decode(input logic eq, input logic gt);
      cmp_res_e res;
      case ({gt, eq})
         2'b00:   res = CMP_LT;
         2'b01:   res = CMP_EQ;
         2'b10:   res = CMP_GT;
         default: res = CMP_XX;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/bcs_based_comparator_slice.sv
// One bit comparator slice.
// It refines the running (eq, gt) verdict coming from the more significant bits
// using this bit pair. Pure combinational logic, built from continuous assigns.
module bcs_slice (
   input  logic eq_in,
   input  logic gt_in,
   input  logic a_i,
   input  logic b_i,
   output logic eq_out,
   output logic gt_out
);

   // Still equal only if every higher bit matched and this bit matches too.
   assign eq_out = eq_in & ~(a_i ^ b_i);

   // Greater once decided above.
   // Otherwise greater at the first differing bit where a has the 1.
   assign gt_out = gt_in | (eq_in & a_i & ~b_i);

endmodule

// File: rtl/bcs_based_comparator.sv
// Unsigned N-bit magnitude comparator built from a ripple chain of bcs_slice cells.
// The chain is scanned from MSB to LSB.
// EQ/GT are the raw combinational chain outputs.
// eq_q/gt_q are one-cycle registered copies for synchronous consumers.
module bcs_based_comparator
   import bcs_based_comparator_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         EQ,
   output logic         GT,
   input  logic         clk,
   input  logic         reset_n,
   output logic         eq_q,
   output logic         gt_q
);

   // Chain nodes: index N is the head seed, index 0 is the LSB slice output.
   logic [N:0] eq_chain_s;
   logic [N:0] gt_chain_s;
   logic       eq_d;
   logic       gt_d;

   assign eq_chain_s[N] = CHAIN_EQ_INIT;
   assign gt_chain_s[N] = CHAIN_GT_INIT;

   // Slice i consumes node i+1 and produces node i.
   // The ripple therefore runs MSB -> LSB.
   for (genvar i = N - 1; i >= 0; i--) begin : g_slice
      bcs_slice u_slice (
         .eq_in  (eq_chain_s[i+1]),
         .gt_in  (gt_chain_s[i+1]),
         .a_i    (a[i]),
         .b_i    (b[i]),
         .eq_out (eq_chain_s[i]),
         .gt_out (gt_chain_s[i])
      );
   end

   assign EQ = eq_chain_s[0];
   assign GT = gt_chain_s[0];

   // Next-state for the output flops is simply the settled chain verdict.
   always_comb begin
      eq_d = 1'b0;
      gt_d = 1'b0;
      if (reset_n) begin
         eq_d = EQ;
         gt_d = GT;
      end else begin
         eq_d = 1'b0;
         gt_d = 1'b0;
      end
   end

   // Output registers.
   // The asynchronous reset clears only these, never the combinational chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         eq_q <= 1'b0;
         gt_q <= 1'b0;
      end else begin
         eq_q <= eq_d;
         gt_q <= gt_d;
      end
   end

endmodule

// File: tb/tb_bcs_based_comparator.sv
// Directed and exhaustive checks for bcs_based_comparator at N=8, plus an N=1 instance.
module tb_bcs_based_comparator;

   logic       clk;
   logic       reset_n;
   logic [7:0] a;
   logic [7:0] b;
   logic       eq_s;
   logic       gt_s;
   logic       eq_q_s;
   logic       gt_q_s;

   logic       a1;
   logic       b1;
   logic       eq1_s;
   logic       gt1_s;
   logic       eq1_q_s;
   logic       gt1_q_s;

   int n_checks;
   int n_errors;

   bcs_based_comparator #(.N(8)) u_dut (
      .a       (a),
      .b       (b),
      .EQ      (eq_s),
      .GT      (gt_s),
      .clk     (clk),
      .reset_n (reset_n),
      .eq_q    (eq_q_s),
      .gt_q    (gt_q_s)
   );

   bcs_based_comparator #(.N(1)) u_dut1 (
      .a       (a1),
      .b       (b1),
      .EQ      (eq1_s),
      .GT      (gt1_s),
      .clk     (clk),
      .reset_n (reset_n),
      .eq_q    (eq1_q_s),
      .gt_q    (gt1_q_s)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset_n  = 1'b0;
      a        = 8'h00;
      b        = 8'h00;
      a1       = 1'b0;
      b1       = 1'b0;

      // Reset state: registered outputs cleared, combinational chain live.
      @(posedge clk);
      #1;
      check_val("rst_eq_q", {31'd0, eq_q_s}, 32'd0);
      check_val("rst_gt_q", {31'd0, gt_q_s}, 32'd0);
      check_val("rst_EQ_comb", {31'd0, eq_s}, 32'd1);

      reset_n = 1'b1;

      // Boundaries and MSB-decides vectors.
      a = 8'h00; b = 8'h00; #1;
      check_val("zero_EQ", {31'd0, eq_s}, 32'd1);
      check_val("zero_GT", {31'd0, gt_s}, 32'd0);
      a = 8'hFF; b = 8'h00; #1;
      check_val("max_GT", {31'd0, gt_s}, 32'd1);
      check_val("max_EQ", {31'd0, eq_s}, 32'd0);
      a = 8'h00; b = 8'hFF; #1;
      check_val("lt_EQ", {31'd0, eq_s}, 32'd0);
      check_val("lt_GT", {31'd0, gt_s}, 32'd0);
      a = 8'h80; b = 8'h7F; #1;
      check_val("msb_gt_GT", {31'd0, gt_s}, 32'd1);
      check_val("msb_gt_EQ", {31'd0, eq_s}, 32'd0);
      a = 8'h7F; b = 8'h80; #1;
      check_val("msb_lt_GT", {31'd0, gt_s}, 32'd0);
      check_val("msb_lt_EQ", {31'd0, eq_s}, 32'd0);
      a = 8'hA5; b = 8'hA5; #1;
      check_val("a5_EQ", {31'd0, eq_s}, 32'd1);
      check_val("a5_GT", {31'd0, gt_s}, 32'd0);
      a = 8'hA4; #1;
      check_val("a4_EQ", {31'd0, eq_s}, 32'd0);
      check_val("a4_GT", {31'd0, gt_s}, 32'd0);

      // Reset mid-operation: gt_q set, then cleared at once between edges.
      @(negedge clk);
      a = 8'd5; b = 8'd3;
      @(posedge clk);
      #1;
      check_val("pre_rst_gt_q", {31'd0, gt_q_s}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("mid_rst_gt_q", {31'd0, gt_q_s}, 32'd0);
      check_val("mid_rst_eq_q", {31'd0, eq_q_s}, 32'd0);
      check_val("mid_rst_GT_comb", {31'd0, gt_s}, 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_val("rel_gt_q_hold", {31'd0, gt_q_s}, 32'd0);
      @(posedge clk);
      #1;
      check_val("rel_gt_q", {31'd0, gt_q_s}, 32'd1);

      // N=1 instance.
      a1 = 1'b0; b1 = 1'b0; #1;
      check_val("n1_00", {30'd0, gt1_s, eq1_s}, 32'd1);
      a1 = 1'b1; b1 = 1'b0; #1;
      check_val("n1_10", {30'd0, gt1_s, eq1_s}, 32'd2);
      a1 = 1'b0; b1 = 1'b1; #1;
      check_val("n1_01", {30'd0, gt1_s, eq1_s}, 32'd0);

      // Exhaustive sweep: combinational after settling, registered one edge later.
      @(negedge clk);
      for (int i = 0; i < 65536; i++) begin
         a = i[15:8];
         b = i[7:0];
         #1;
         check_val("ex_EQ", {31'd0, eq_s}, {31'd0, (i[15:8] == i[7:0])});
         check_val("ex_GT", {31'd0, gt_s}, {31'd0, (i[15:8] > i[7:0])});
         @(posedge clk);
         #1;
         check_val("ex_eq_q", {31'd0, eq_q_s}, {31'd0, (i[15:8] == i[7:0])});
         check_val("ex_gt_q", {31'd0, gt_q_s}, {31'd0, (i[15:8] > i[7:0])});
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
